// File: rtl/dmem_responder.sv
// Data-memory responder for the rv32i load/store path: one request at a time, programmable
// wait states, lane-extracted and sign/zero-extended load data, error flag for bad accesses.
module dmem_responder #(
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W   = 30'(DEPTH);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic        wr_r;
  logic [2:0]  f3_r;
  logic [31:0] addr_r, wdata_r;
  logic [31:0] rdata_r;
  logic        err_r;
  logic [31:0] mem_r [DEPTH];

  logic        accept_s, commit_s, err_s, cur_wr_s;
  logic [2:0]  cur_f3_s;
  logic [31:0] cur_addr_s, cur_wdata_s, rd_word_s;
  logic [AW-1:0] idx_s;

  function automatic logic access_error(input logic wr, input logic [2:0] f3,
                                        input logic [31:0] addr);
    logic bad_f3;
    if (wr) begin
      bad_f3 = (f3 > 3'b010);
    end else begin
      bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
    return bad_f3
        || ((f3[1:0] == 2'b01) && addr[0])
        || ((f3 == 3'b010) && (addr[1:0] != 2'b00))
        || (addr[31:2] >= DEPTH_W);
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] r;
    r = old;
    case (f3)
      3'b000: r[{lane, 3'b000} +: 8] = wdata[7:0];
      3'b001: begin
        if (lane[1]) begin
          r[31:16] = wdata[15:0];
        end else begin
          r[15:0] = wdata[15:0];
        end
      end
      3'b010:  r = wdata;
      default: r = old;
    endcase
    return r;
  endfunction

  assign req_ready = (state_r == ST_IDLE) && rst_n;
  assign accept_s  = req_valid && req_ready;
  assign rsp_valid = (state_r == ST_RESP);
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;

  // Zero wait states commit on the accept edge, so the live inputs feed the datapath in IDLE
  assign cur_wr_s    = (state_r == ST_IDLE) ? req_write  : wr_r;
  assign cur_f3_s    = (state_r == ST_IDLE) ? req_funct3 : f3_r;
  assign cur_addr_s  = (state_r == ST_IDLE) ? req_addr   : addr_r;
  assign cur_wdata_s = (state_r == ST_IDLE) ? req_wdata  : wdata_r;
  assign idx_s       = cur_addr_s[AW+1:2];
  assign rd_word_s   = mem_r[idx_s];
  assign err_s       = access_error(cur_wr_s, cur_f3_s, cur_addr_s);
  assign commit_s    = (state_nxt_s == ST_RESP) && (state_r != ST_RESP);

  // Next-state and wait-counter logic
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt_s = ST_RESP;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = WAIT_INIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_RESP;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State, request capture and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      wr_r    <= 1'b0;
      f3_r    <= 3'd0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (accept_s) begin
        wr_r    <= req_write;
        f3_r    <= req_funct3;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
      if (commit_s) begin
        err_r   <= err_s;
        rdata_r <= (err_s || cur_wr_s) ? 32'd0 : load_extend(rd_word_s, cur_f3_s, cur_addr_s[1:0]);
      end else if ((state_r == ST_RESP) && rsp_ready) begin
        err_r   <= 1'b0;
        rdata_r <= 32'd0;
      end
    end
  end

  // Array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (commit_s && cur_wr_s && !err_s) begin
      mem_r[idx_s] <= store_merge(rd_word_s, cur_wdata_s, cur_f3_s, cur_addr_s[1:0]);
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on a WAIT_CYCLES=1 instance, plus hold,
// reset-abort, latency and back-to-back sequences on WAIT_CYCLES=0/3 instances.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req_valid = 3'b000;
  logic [2:0]  req_ready;
  logic [2:0]  req_write = 3'b000;
  logic [2:0]  req_funct3 [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_ready = 3'b000;
  logic [31:0] rsp_rdata  [3];
  logic [2:0]  rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WC = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    dmem_responder #(.DEPTH(512), .WAIT_CYCLES(WC)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
      .req_funct3(req_funct3[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
    );
  end

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic xact(input int d, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic e,
                      output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_timeout", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_write[d] = wr; req_funct3[d] = f3;
    req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    req_addr[d] = 32'hFFFF_FFFF; req_wdata[d] = 32'h0; req_funct3[d] = 3'b111;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[d] && lat < 50);
    chk("rsp_valid_timeout", 32'(rsp_valid[d]), 32'd1);
    rd = rsp_rdata[d];
    e  = rsp_err[d];
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[d] = 1'b0;
  endtask

  task automatic b2b(input int d, input int period);
    int n, first, cnt;
    n = 0; first = -1; cnt = 1;
    req_valid[d] = 1'b1; req_write[d] = 1'b0; req_funct3[d] = 3'b010;
    req_addr[d] = 32'h0000_0800; rsp_ready[d] = 1'b1;
    @(negedge clk);
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 1; i < 2 * period; i++) begin
      @(negedge clk);
      if (req_ready[d]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    chk($sformatf("b2b%0d_gap", d), 32'(first), 32'(period));
    chk($sformatf("b2b%0d_ready_cycles", d), 32'(cnt), 32'd2);
    req_valid[d] = 1'b0;
    repeat (8) @(negedge clk);
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          n;

    for (int i = 0; i < 3; i++) begin
      req_funct3[i] = 3'b000; req_addr[i] = 32'd0; req_wdata[i] = 32'd0;
    end

    //        wr    f3      addr           wdata          exp_rdata      exp_err
    vecs.push_back('{1'b1, 3'b010, 32'h0000_0010, 32'h1234_ABCD, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h1234_ABCD, 1'b0});
    vecs.push_back('{1'b1, 3'b000, 32'h0000_0013, 32'hAAAA_AA80, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 32'h0000_0013, 32'h0,         32'hFFFF_FF80, 1'b0});
    vecs.push_back('{1'b0, 3'b100, 32'h0000_0013, 32'h0,         32'h0000_0080, 1'b0});
    vecs.push_back('{1'b0, 3'b001, 32'h0000_0010, 32'h0,         32'hFFFF_ABCD, 1'b0});
    vecs.push_back('{1'b0, 3'b101, 32'h0000_0012, 32'h0,         32'h0000_8034, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h0000_0012, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 3'b001, 32'h0000_0011, 32'h0000_FFFF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'b010, 32'h0000_0800, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'b011, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 3'b011, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 3'b100, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'b110, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'b111, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'b101, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'b000, 32'h0000_0801, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h8034_ABCD, 1'b0});
    vecs.push_back('{1'b1, 3'b001, 32'h0000_0012, 32'h5555_1122, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h1122_ABCD, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 32'h0000_0010, 32'h0,         32'hFFFF_FFCD, 1'b0});
    vecs.push_back('{1'b0, 3'b100, 32'h0000_0011, 32'h0,         32'h0000_00AB, 1'b0});
    vecs.push_back('{1'b0, 3'b001, 32'h0000_0012, 32'h0,         32'h0000_1122, 1'b0});
    vecs.push_back('{1'b1, 3'b010, 32'h0000_07FC, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 32'h0000_07FF, 32'h0,         32'hFFFF_FFDE, 1'b0});
    vecs.push_back('{1'b0, 3'b101, 32'h0000_07FE, 32'h0,         32'h0000_DEAD, 1'b0});
    vecs.push_back('{1'b0, 3'b001, 32'h0000_07FC, 32'h0,         32'hFFFF_BEEF, 1'b0});

    // Reset state
    #2;
    chk("rst_req_ready", 32'(req_ready[0]), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata[0], 32'd0);
    chk("rst_rsp_err", 32'(rsp_err[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_req_ready", 32'(req_ready[0]), 32'd1);

    foreach (vecs[i]) begin
      xact(0, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, e, lat);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
    end

    // Response held while rsp_ready is low; stray req_valid pulses must be ignored
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_funct3[0] = 3'b010; req_addr[0] = 32'h10;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[0] && n < 50);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("hold%0d_valid", i), 32'(rsp_valid[0]), 32'd1);
      chk($sformatf("hold%0d_rdata", i), rsp_rdata[0], 32'h1122_ABCD);
      chk($sformatf("hold%0d_req_ready", i), 32'(req_ready[0]), 32'd0);
      req_valid[0] = (i == 1 || i == 3);
      req_write[0] = 1'b1; req_funct3[0] = 3'b010; req_wdata[0] = 32'h0;
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[0] = 1'b0;
    chk("hold_release_valid", 32'(rsp_valid[0]), 32'd0);
    chk("hold_release_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    chk("hold_no_stray_accept", 32'(rsp_valid[0]), 32'd0);
    xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat);
    chk("hold_mem_unchanged", rd, 32'h1122_ABCD);

    // Reset while a store waits: store is dropped, outputs clear immediately
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_funct3[0] = 3'b010;
    req_addr[0] = 32'h10; req_wdata[0] = 32'hCAFE_F00D;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready[0]), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("abort_rsp_rdata", rsp_rdata[0], 32'd0);
    chk("abort_rsp_err", 32'(rsp_err[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat);
    chk("abort_old_value", rd, 32'h1122_ABCD);

    // Latency and back-to-back spacing for zero and three wait states
    xact(1, 1'b1, 3'b010, 32'h20, 32'h0BAD_F00D, rd, e, lat);
    chk("w0_latency", 32'(lat), 32'd1);
    xact(1, 1'b0, 3'b101, 32'h22, 32'h0, rd, e, lat);
    chk("w0_lhu", rd, 32'h0000_0BAD);
    xact(2, 1'b1, 3'b010, 32'h20, 32'h8765_4321, rd, e, lat);
    chk("w3_latency", 32'(lat), 32'd4);
    xact(2, 1'b0, 3'b000, 32'h23, 32'h0, rd, e, lat);
    chk("w3_lb", rd, 32'hFFFF_FF87);
    b2b(1, 2);
    b2b(2, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
